// File: rtl/result_line_packer_if.sv
// Packed-line output stream of result_line_packer (valid/ready).
// RESULT_NODE_MAX_EXP_EN adds the per-node max exponent sideband.
interface result_line_packer_if;
   logic [255:0] out_data;
   logic         out_vld;
   logic         out_ready;
   logic         out_last;
`ifdef RESULT_NODE_MAX_EXP_EN
   logic [7:0]   out_max_exp;

   modport master (output out_data, output out_vld, output out_last,
                   output out_max_exp, input out_ready);
   modport slave  (input out_data, input out_vld, input out_last,
                   input out_max_exp, output out_ready);
`else
   modport master (output out_data, output out_vld, output out_last,
                   input out_ready);
   modport slave  (input out_data, input out_vld, input out_last,
                   output out_ready);
`endif
endinterface

// File: rtl/result_line_packer.sv
// Packs 128-bit bf16 result pairs into 256-bit lines held in a FIFO with node-last marking.
// Optional RESULT_NODE_MAX_EXP_EN carries the node's max lane exponent on the last line.
module result_line_packer #(
   parameter int DEPTH        = 16,
   parameter int ADDR_W       = 4,
   parameter int AFULL_THRESH = 12
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [127:0]        res_data,
   input  logic                res_vld,
   input  logic [10:0]         lines_per_node_minusone,
   result_line_packer_if.master out_if,
   output logic [ADDR_W:0]     fifo_count,
   output logic                almost_full,
   output logic                overflow
);

`ifdef RESULT_NODE_MAX_EXP_EN
   localparam int ENTRY_W = 265;
`else
   localparam int ENTRY_W = 257;
`endif

   typedef enum logic {EMPTY, LOW_HELD} state_t;

   state_t         state, state_nxt;
   logic [10:0]    res_cnt;
   logic [127:0]   low_reg;
   logic           res_last;
   logic           push, push_last, latch_low;
   logic [255:0]   push_line;
   logic [ENTRY_W-1:0] push_entry;

   assign res_last = (res_cnt == lines_per_node_minusone);

   always_ff @(posedge clk) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (res_vld) begin
         case (state)
            EMPTY:    if (!res_last) state_nxt = LOW_HELD;
            LOW_HELD: state_nxt = EMPTY;
         endcase
      end
   end

   always_comb begin
      push      = 1'b0;
      push_last = 1'b0;
      push_line = '0;
      latch_low = 1'b0;
      if (res_vld) begin
         case (state)
            EMPTY: begin
               if (res_last) begin
                  push      = 1'b1;
                  push_last = 1'b1;
                  push_line = {128'h0, res_data};
               end else begin
                  latch_low = 1'b1;
               end
            end
            LOW_HELD: begin
               push      = 1'b1;
               push_last = res_last;
               push_line = {res_data, low_reg};
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         res_cnt <= '0;
         low_reg <= '0;
      end else begin
         if (res_vld) res_cnt <= res_last ? '0 : res_cnt + 11'd1;
         if (latch_low) low_reg <= res_data;
      end
   end

`ifdef RESULT_NODE_MAX_EXP_EN
   logic [7:0] max_run, lane_max, node_max;

   // Only real results feed the max, so padding lanes never contribute.
   always_comb begin
      lane_max = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (res_data[16*i+7 +: 8] > lane_max) lane_max = res_data[16*i+7 +: 8];
      end
      node_max = (lane_max > max_run) ? lane_max : max_run;
   end

   always_ff @(posedge clk) begin
      if (rst)          max_run <= '0;
      else if (res_vld) max_run <= res_last ? '0 : node_max;
   end

   assign push_entry = {(push_last ? node_max : 8'h00), push_last, push_line};
`else
   assign push_entry = {push_last, push_line};
`endif

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0]  wr_ptr, rd_ptr;
   logic [ENTRY_W-1:0] head;
   logic               full, empty, pop, wr_en;

   assign full  = (fifo_count == (ADDR_W+1)'(DEPTH));
   assign empty = (fifo_count == '0);
   assign pop   = !empty && out_if.out_ready;
   // A full FIFO still takes a line when the head leaves in the same cycle.
   assign wr_en = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (!rst && wr_en) mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         if (push && full && !pop) overflow <= 1'b1;
      end
   end

   assign head        = mem[rd_ptr];
   assign almost_full = (fifo_count >= (ADDR_W+1)'(AFULL_THRESH));

   assign out_if.out_vld  = !empty;
   assign out_if.out_data = empty ? '0 : head[255:0];
   assign out_if.out_last = !empty && head[256];
`ifdef RESULT_NODE_MAX_EXP_EN
   assign out_if.out_max_exp = empty ? 8'h00 : head[264:257];
`endif

endmodule

// File: tb/tb_result_line_packer.sv
// Scoreboard bench for result_line_packer: stimulus queues expected lines, a monitor checks handshakes.
module tb_result_line_packer;
   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] res_data;
   logic         res_vld;
   logic [10:0]  lpn;
   logic [4:0]   fifo_count;
   logic         almost_full;
   logic         overflow;

   result_line_packer_if out_if ();

   result_line_packer #(.DEPTH(16), .ADDR_W(4), .AFULL_THRESH(12)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .res_data                (res_data),
      .res_vld                 (res_vld),
      .lines_per_node_minusone (lpn),
      .out_if                  (out_if.master),
      .fifo_count              (fifo_count),
      .almost_full             (almost_full),
      .overflow                (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [255:0] data;
      logic         last;
      logic         chk_mx;
      logic [7:0]   mx;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   errors = 0;
   int   checks = 0;
   int   peak   = 0;

   function automatic logic [127:0] res(input int i);
      logic [127:0] r;
      for (int l = 0; l < 8; l++) r[16*l +: 16] = 16'(i*8 + l);
      return r;
   endfunction

   function automatic logic [127:0] mkexp(input logic [63:0] ex);
      logic [127:0] r;
      for (int l = 0; l < 8; l++) r[16*l +: 16] = {1'b0, ex[8*l +: 8], 7'h00};
      return r;
   endfunction

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic expect_line(input logic [127:0] hi, input logic [127:0] lo, input logic last,
                              input logic chk_mx = 1'b0, input logic [7:0] mx = 8'h00);
      exp_t x;
      x.data = {hi, lo};
      x.last = last;
      x.chk_mx = chk_mx;
      x.mx = mx;
      q.push_back(x);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [127:0] d);
      res_vld  = 1'b1;
      res_data = d;
      step();
   endtask

   task automatic idle(input int n);
      res_vld = 1'b0;
      repeat (n) step();
   endtask

   task automatic drain();
      res_vld = 1'b0;
      out_if.out_ready = 1'b1;
      for (int i = 0; i < 64 && out_if.out_vld; i++) step();
      chk("drain_done", 256'(out_if.out_vld), 256'(0));
   endtask

   // Monitor: samples mid-cycle, the pop itself happens on the following edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (int'(fifo_count) > peak) peak = int'(fifo_count);
         if (out_if.out_vld && out_if.out_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_line: got %h expected none", out_if.out_data);
            end else begin
               e = q.pop_front();
               chk("line_data", out_if.out_data, e.data);
               chk("line_last", 256'(out_if.out_last), 256'(e.last));
`ifdef RESULT_NODE_MAX_EXP_EN
               if (!e.last || e.chk_mx) chk("max_exp", 256'(out_if.out_max_exp), 256'(e.mx));
`endif
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; res_vld = 1'b0; res_data = '0; lpn = '0; out_if.out_ready = 1'b0;
      repeat (3) step();
      chk("rst_out_vld",   256'(out_if.out_vld),  256'(0));
      chk("rst_out_last",  256'(out_if.out_last), 256'(0));
      chk("rst_out_data",  out_if.out_data,       256'(0));
      chk("rst_count",     256'(fifo_count),      256'(0));
      chk("rst_afull",     256'(almost_full),     256'(0));
      chk("rst_overflow",  256'(overflow),        256'(0));
      rst = 1'b0;
      step();

      // Even node of 4 results, streaming out immediately.
      lpn = 11'd3; out_if.out_ready = 1'b1; peak = 0;
      expect_line(res(2), res(1), 1'b0);
      expect_line(res(4), res(3), 1'b1);
      for (int i = 1; i <= 4; i++) send(res(i));
      idle(3);
      chk("peak_count", 256'(peak), 256'(1));

      // Odd nodes of 3: padded final line, no cross-node packing.
      lpn = 11'd2;
      expect_line(res(12), res(11), 1'b0);
      expect_line(128'h0,  res(13), 1'b1);
      expect_line(res(22), res(21), 1'b0);
      expect_line(128'h0,  res(23), 1'b1);
      send(res(11)); send(res(12)); send(res(13));
      send(res(21)); send(res(22)); send(res(23));
      idle(4);

      // Fill to full with no drain, then overflow.
      out_if.out_ready = 1'b0; lpn = 11'd31;
      for (int k = 0; k < 16; k++) expect_line(res(101 + 2*k), res(100 + 2*k), k == 15);
      for (int j = 0; j < 32; j++) begin
         send(res(100 + j));
         if (j % 2 == 1) begin
            chk("fill_count", 256'(fifo_count), 256'((j + 1) / 2));
            chk("fill_afull", 256'(almost_full), 256'(((j + 1) / 2) >= 12));
         end
      end
      res_vld = 1'b0;
      chk("full_no_ovf", 256'(overflow), 256'(0));
      send(res(132)); send(res(133));
      res_vld = 1'b0;
      chk("ovf_set",      256'(overflow),   256'(1));
      chk("ovf_count",    256'(fifo_count), 256'(16));
      chk("ovf_head",     out_if.out_data,  {res(101), res(100)});
      idle(2);
      chk("ovf_sticky",   256'(overflow),   256'(1));

      rst = 1'b1; step(); rst = 1'b0;
      q.delete();
      chk("rst_clr_ovf",   256'(overflow),   256'(0));
      chk("rst_clr_count", 256'(fifo_count), 256'(0));

      // Full FIFO takes a push when a pop happens in the same cycle.
      for (int k = 0; k < 16; k++) expect_line(res(201 + 2*k), res(200 + 2*k), k == 15);
      for (int j = 0; j < 32; j++) send(res(200 + j));
      send(res(232));
      res_vld = 1'b0;
      chk("pre_pp_count", 256'(fifo_count), 256'(16));
      expect_line(res(233), res(232), 1'b0);
      out_if.out_ready = 1'b1;
      send(res(233));
      res_vld = 1'b0;
      out_if.out_ready = 1'b0;
      chk("pp_count",    256'(fifo_count), 256'(16));
      chk("pp_overflow", 256'(overflow),   256'(0));
      drain();

      // Reset while a low half is held and lines are stored.
      out_if.out_ready = 1'b0;
      for (int j = 0; j < 7; j++) send(res(300 + j));
      res_vld = 1'b0;
      chk("pre_rst_count", 256'(fifo_count), 256'(3));
      rst = 1'b1; step(); rst = 1'b0;
      chk("mid_rst_vld",   256'(out_if.out_vld), 256'(0));
      chk("mid_rst_count", 256'(fifo_count),     256'(0));
      lpn = 11'd1; out_if.out_ready = 1'b1;
      expect_line(res(401), res(400), 1'b1);
      send(res(400)); send(res(401));
      idle(3);

`ifdef RESULT_NODE_MAX_EXP_EN
      expect_line(mkexp(64'h01_83_02_10_03_04_05_06), mkexp(64'h10_20_30_7F_05_06_07_08),
                  1'b1, 1'b1, 8'h83);
      expect_line(mkexp(64'h11_00_01_02_03_04_05_06), mkexp(64'h20_01_02_03_04_05_06_07),
                  1'b1, 1'b1, 8'h20);
      send(mkexp(64'h10_20_30_7F_05_06_07_08));
      send(mkexp(64'h01_83_02_10_03_04_05_06));
      send(mkexp(64'h20_01_02_03_04_05_06_07));
      send(mkexp(64'h11_00_01_02_03_04_05_06));
      idle(3);
`endif

      drain();
      chk("queue_empty", 256'(q.size()), 256'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
